// File: rtl/digi_ota_pkg.sv
// Shared types and defaults for the OTA calibration sequencer.
// State encoding, parameter defaults and the midscale trim helper.
package digi_ota_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL_SETTLE,
    ST_CAL_VOTE,
    ST_SMP_SETTLE,
    ST_SMP_CAPTURE
  } state_t;

  localparam int TRIM_W_DEF     = 5;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int VOTE_LOG2_DEF  = 2;

  function automatic logic [31:0] TRIM_MID(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/digi_ota_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Both stages clear to 0 on reset.
module digi_ota_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the raw level through two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/digi_ota_cal_ctrl.sv
// SAR offset-trim calibration and periodic sample scheduler
// for the digital OTA/comparator macro.
module digi_ota_cal_ctrl
  import digi_ota_pkg::*;
#(
  parameter int TRIM_W     = TRIM_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int VOTE_LOG2  = VOTE_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start_cal,
  input  logic              run,
  input  logic              cmp_in,
  output logic              ota_en,
  output logic              short_in,
  output logic [TRIM_W-1:0] trim,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              sample_valid,
  output logic              sample_bit
);

  localparam int CW    = 8;
  localparam int VW    = VOTE_LOG2 + 1;
  localparam int VOTES = 1 << VOTE_LOG2;
  localparam int IW    = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] MID = TRIM_W'(TRIM_MID(TRIM_W));

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic [VW-1:0]   ones;
  logic [VW-1:0]   ones_tot;
  logic [IW-1:0]   bit_idx;
  logic            cmp_s;
  logic            settle_done;
  logic            vote_last;
  logic            maj;
  logic            last_bit;
  logic            cal_st;
  logic            start_go;
  logic            cap_ok;

  digi_ota_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  assign settle_done = cnt == CW'(SETTLE_CYC - 1);
  assign vote_last   = cnt == CW'(VOTES - 1);
  assign ones_tot    = ones + VW'(cmp_s);
  assign maj         = ones_tot > VW'(VOTES / 2);
  assign last_bit    = bit_idx == '0;
  assign cal_st      = (state == ST_CAL_SETTLE) ||
                       (state == ST_CAL_VOTE);
  assign start_go    = (nxt == ST_CAL_SETTLE) && !cal_st;
  assign cap_ok      = ena && (state == ST_SMP_CAPTURE) &&
                       !start_cal;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // next-state decode; ena low overrides everything
  always_comb begin
    nxt = state;
    if (!ena) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_cal)  nxt = ST_CAL_SETTLE;
          else if (run)   nxt = ST_SMP_SETTLE;
        end
        ST_CAL_SETTLE: begin
          if (settle_done) nxt = ST_CAL_VOTE;
        end
        ST_CAL_VOTE: begin
          if (vote_last)
            nxt = last_bit ? ST_IDLE : ST_CAL_SETTLE;
        end
        ST_SMP_SETTLE: begin
          if (start_cal)        nxt = ST_CAL_SETTLE;
          else if (settle_done) nxt = ST_SMP_CAPTURE;
        end
        ST_SMP_CAPTURE: begin
          if (start_cal) nxt = ST_CAL_SETTLE;
          else if (run)  nxt = ST_SMP_SETTLE;
          else           nxt = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // level outputs straight from the state
  always_comb begin
    ota_en   = state != ST_IDLE;
    short_in = cal_st;
    cal_busy = cal_st;
  end

  // dwell counter and vote accumulator, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ones <= '0;
    end else begin
      if (state == ST_IDLE || nxt != state) cnt <= '0;
      else                                  cnt <= cnt + CW'(1);
      if (state == ST_CAL_VOTE && nxt == state) ones <= ones_tot;
      else                                      ones <= '0;
    end
  end

  // SAR trim register: trial bit set, resolved by majority, then next bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trim    <= MID;
      bit_idx <= '0;
    end else if (!ena) begin
      if (cal_st) trim <= MID;
    end else if (start_go) begin
      trim    <= MID;
      bit_idx <= IW'(TRIM_W - 1);
    end else if (state == ST_CAL_VOTE && vote_last) begin
      trim[bit_idx] <= !maj;
      if (!last_bit) begin
        trim[bit_idx - IW'(1)] <= 1'b1;
        bit_idx <= bit_idx - IW'(1);
      end
    end
  end

  // registered pulses and captured decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_done     <= 1'b0;
      sample_valid <= 1'b0;
      sample_bit   <= 1'b0;
    end else begin
      cal_done     <= ena && state == ST_CAL_VOTE &&
                      vote_last && last_bit;
      sample_valid <= cap_ok;
      if (cap_ok) sample_bit <= cmp_s;
    end
  end

endmodule
